// File: rtl/pw_cache_pkg.sv
// Shared types for the page-walk cache: tag/data widths, the table entry layout,
// and the classification of a fill request.
package pw_cache_pkg;

  localparam int PWC_TAG_W  = 16;
  localparam int PWC_DATA_W = 16;

  typedef logic [PWC_TAG_W-1:0]  pwc_tag_t;
  typedef logic [PWC_DATA_W-1:0] pwc_data_t;

  typedef struct packed {
    logic      vld;
    pwc_tag_t  tag;
    pwc_data_t pa;
  } pwc_entry_t;

  // How a fill lands in the table.
  typedef enum logic [1:0] {
    FILL_NONE,
    FILL_UPDATE,
    FILL_FREE,
    FILL_EVICT
  } fill_kind_t;

endpackage

// File: rtl/pw_cache_match.sv
// Combinational tag search over the entry table: one-hot match, matched PA, and
// the lowest-index invalid slot.
module pw_cache_match
  import pw_cache_pkg::*;
#(
  parameter int ENTRIES = 8,
  parameter int IDX_W   = 3
) (
  input  pwc_entry_t [ENTRIES-1:0] entries,
  input  pwc_tag_t                 tag,
  output logic [ENTRIES-1:0]       match,
  output logic                     hit,
  output pwc_data_t                pa,
  output logic [IDX_W-1:0]         free_idx,
  output logic                     free
);

  logic [ENTRIES-1:0] invalid;

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_cmp
    assign match[gi]   = entries[gi].vld && (entries[gi].tag == tag);
    assign invalid[gi] = !entries[gi].vld;
  end

  assign hit  = |match;
  assign free = |invalid;

  // Fills keep tags unique, so OR-ing the selected PAs yields the single match.
  always_comb begin
    pa = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (match[i]) pa = pa | entries[i].pa;
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (invalid[i]) free_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/pw_cache.sv
// Page-walk cache: fully-associative VA[31:16] -> PA[31:16] table with a fixed
// two-cycle lookup pipeline, fill/flush maintenance and hit/miss statistics.
module pw_cache
  import pw_cache_pkg::*;
#(
  parameter int ENTRIES = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic [31:0]      pw_c_va_i,
  input  logic             pw_c_vld_i,
  output logic [15:0]      pw_c_pa_o,
  output logic             pw_c_pa_vld_o,
  output logic             pw_c_hit_o,
  input  logic             fill_vld_i,
  input  logic [15:0]      fill_tag_i,
  input  logic [15:0]      fill_pa_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] hit_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  pwc_entry_t [ENTRIES-1:0] entries_reg;
  logic [IDX_W-1:0]         rr_ptr_reg;
  logic [IDX_W-1:0]         rr_ptr_next;

  logic                     s1_vld_reg;
  pwc_tag_t                 s1_tag_reg;
  logic                     s2_vld_reg;
  logic                     s2_hit_reg;
  pwc_data_t                s2_pa_reg;
  logic [CNT_W-1:0]         hit_cnt_reg;
  logic [CNT_W-1:0]         miss_cnt_reg;

  logic [ENTRIES-1:0]       lk_match;
  logic                     lk_hit;
  pwc_data_t                lk_pa;
  logic [IDX_W-1:0]         lk_free_idx;
  logic                     lk_free;

  logic [ENTRIES-1:0]       fl_match;
  logic                     fl_hit;
  pwc_data_t                fl_pa;
  logic [IDX_W-1:0]         fl_free_idx;
  logic                     fl_free;

  fill_kind_t               fill_kind;
  logic [IDX_W-1:0]         upd_idx;
  logic [IDX_W-1:0]         wr_idx;
  logic                     lk_resp_hit;

  pw_cache_match #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W)
  ) u_lookup_match (
    .entries  (entries_reg),
    .tag      (s1_tag_reg),
    .match    (lk_match),
    .hit      (lk_hit),
    .pa       (lk_pa),
    .free_idx (lk_free_idx),
    .free     (lk_free)
  );

  pw_cache_match #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W)
  ) u_fill_match (
    .entries  (entries_reg),
    .tag      (fill_tag_i),
    .match    (fl_match),
    .hit      (fl_hit),
    .pa       (fl_pa),
    .free_idx (fl_free_idx),
    .free     (fl_free)
  );

  // Flush wins over a same-cycle fill.
  always_comb begin
    fill_kind = FILL_NONE;
    if (fill_vld_i && !flush_i) begin
      if (fl_hit) begin
        fill_kind = FILL_UPDATE;
      end else if (fl_free) begin
        fill_kind = FILL_FREE;
      end else begin
        fill_kind = FILL_EVICT;
      end
    end
  end

  always_comb begin
    upd_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (fl_match[i]) upd_idx = upd_idx | IDX_W'(i);
    end
  end

  // Only eviction advances the round-robin victim pointer.
  always_comb begin
    wr_idx      = rr_ptr_reg;
    rr_ptr_next = rr_ptr_reg;
    case (fill_kind)
      FILL_UPDATE: wr_idx = upd_idx;
      FILL_FREE:   wr_idx = fl_free_idx;
      FILL_EVICT:  rr_ptr_next = rr_ptr_reg + IDX_W'(1);
      default:     wr_idx = rr_ptr_reg;
    endcase
    if (flush_i) rr_ptr_next = '0;
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      entries_reg <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entries_reg[i].vld <= 1'b0;
      end
    end else if (fill_kind != FILL_NONE) begin
      entries_reg[wr_idx] <= '{vld: 1'b1, tag: fill_tag_i, pa: fill_pa_i};
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      rr_ptr_reg <= '0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  // S1 holds the request; its compare runs against the table already updated
  // by any fill/flush sampled alongside it.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      s1_vld_reg <= 1'b0;
      s1_tag_reg <= '0;
    end else begin
      s1_vld_reg <= pw_c_vld_i;
      s1_tag_reg <= pw_c_va_i[31:16];
    end
  end

  assign lk_resp_hit = s1_vld_reg && lk_hit;

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      s2_vld_reg <= 1'b0;
      s2_hit_reg <= 1'b0;
      s2_pa_reg  <= '0;
    end else begin
      s2_vld_reg <= s1_vld_reg;
      s2_hit_reg <= lk_resp_hit;
      s2_pa_reg  <= lk_resp_hit ? lk_pa : '0;
    end
  end

  // Counters load with S2 so they already include the response on the outputs.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
    end else if (s1_vld_reg) begin
      if (lk_hit) begin
        if (hit_cnt_reg != CNT_MAX) hit_cnt_reg <= hit_cnt_reg + CNT_W'(1);
      end else begin
        if (miss_cnt_reg != CNT_MAX) miss_cnt_reg <= miss_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign pw_c_pa_vld_o = s2_vld_reg;
  assign pw_c_hit_o    = s2_hit_reg;
  assign pw_c_pa_o     = s2_pa_reg;
  assign hit_cnt_o     = hit_cnt_reg;
  assign miss_cnt_o    = miss_cnt_reg;

  logic unused_sig;
  assign unused_sig = ^{pw_c_va_i[15:0], lk_match, lk_free_idx, lk_free, fl_pa};

endmodule

// File: tb/tb_pw_cache.sv
// Self-checking bench for pw_cache: directed scenarios plus a randomized run, all
// checked against a behavioural table model kept in the bench.
module tb_pw_cache;

  localparam int ENT  = 8;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk_i = 1'b0;
  logic          resetn_i = 1'b0;
  logic [31:0]   pw_c_va_i = '0;
  logic          pw_c_vld_i = 1'b0;
  logic [15:0]   pw_c_pa_o;
  logic          pw_c_pa_vld_o;
  logic          pw_c_hit_o;
  logic          fill_vld_i = 1'b0;
  logic [15:0]   fill_tag_i = '0;
  logic [15:0]   fill_pa_i = '0;
  logic          flush_i = 1'b0;
  logic [CW-1:0] hit_cnt_o;
  logic [CW-1:0] miss_cnt_o;

  int checks = 0;
  int failures = 0;

  // Reference model: table contents, victim pointer, raw response counts.
  bit          m_vld [ENT];
  logic [15:0] m_tag [ENT];
  logic [15:0] m_pa  [ENT];
  int          m_rr;
  int          m_hits;
  int          m_misses;
  bit          pend_vld, pend_hit;
  logic [15:0] pend_pa, pend_tag;
  bit          exp_vld, exp_hit;
  logic [15:0] exp_pa;

  pw_cache #(
    .ENTRIES (ENT),
    .CNT_W   (CW)
  ) dut (
    .clk_i         (clk_i),
    .resetn_i      (resetn_i),
    .pw_c_va_i     (pw_c_va_i),
    .pw_c_vld_i    (pw_c_vld_i),
    .pw_c_pa_o     (pw_c_pa_o),
    .pw_c_pa_vld_o (pw_c_pa_vld_o),
    .pw_c_hit_o    (pw_c_hit_o),
    .fill_vld_i    (fill_vld_i),
    .fill_tag_i    (fill_tag_i),
    .fill_pa_i     (fill_pa_i),
    .flush_i       (flush_i),
    .hit_cnt_o     (hit_cnt_o),
    .miss_cnt_o    (miss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [CW-1:0] sat(input int n);
    return (n > CMAX) ? CW'(CMAX) : CW'(n);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENT; i++) begin
      m_vld[i] = 1'b0; m_tag[i] = '0; m_pa[i] = '0;
    end
    m_rr = 0; m_hits = 0; m_misses = 0;
    pend_vld = 1'b0; pend_hit = 1'b0; pend_pa = '0; pend_tag = '0;
  endtask

  // One clock: drive inputs, let the edge sample them, then advance the model.
  // exp_* afterwards describe what the DUT must be showing right now.
  task automatic step(input bit req, input logic [31:0] va, input bit fv,
                      input logic [15:0] ft, input logic [15:0] fp, input bit fl);
    int slot;
    pw_c_vld_i = req; pw_c_va_i = va; fill_vld_i = fv;
    fill_tag_i = ft; fill_pa_i = fp; flush_i = fl;
    @(posedge clk_i);
    #1;
    pw_c_vld_i = 1'b0; fill_vld_i = 1'b0; flush_i = 1'b0;
    exp_vld = pend_vld; exp_hit = pend_hit; exp_pa = pend_pa;
    if (pend_vld) begin
      if (pend_hit) m_hits++; else m_misses++;
      $display("resp tag=%h hit=%0d pa=%h (dut hit=%0d pa=%h)",
               pend_tag, pend_hit, pend_pa, pw_c_hit_o, pw_c_pa_o);
    end
    if (fl) begin
      for (int i = 0; i < ENT; i++) m_vld[i] = 1'b0;
      m_rr = 0;
    end else if (fv) begin
      slot = -1;
      for (int i = 0; i < ENT; i++) if (m_vld[i] && m_tag[i] == ft) slot = i;
      if (slot < 0) for (int i = ENT - 1; i >= 0; i--) if (!m_vld[i]) slot = i;
      if (slot < 0) begin
        slot = m_rr;
        m_rr = (m_rr + 1) % ENT;
      end
      m_vld[slot] = 1'b1; m_tag[slot] = ft; m_pa[slot] = fp;
    end
    pend_vld = req; pend_hit = 1'b0; pend_pa = '0; pend_tag = va[31:16];
    if (req) begin
      for (int i = 0; i < ENT; i++) begin
        if (m_vld[i] && m_tag[i] == va[31:16]) begin
          pend_hit = 1'b1; pend_pa = m_pa[i];
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if ({pw_c_pa_vld_o, pw_c_hit_o, pw_c_pa_o, hit_cnt_o, miss_cnt_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got vld=%0d hit=%0d pa=%h hc=%0d mc=%0d, want all 0",
               pw_c_pa_vld_o, pw_c_hit_o, pw_c_pa_o, hit_cnt_o, miss_cnt_o);
    end
    resetn_i = 1'b1;
    model_reset();
    $display("reset released");
  endtask

  task automatic test_miss_after_reset();
    step(1'b1, 32'h1234_5678, 1'b0, '0, '0, 1'b0);
    step(1'b0, '0, 1'b0, '0, '0, 1'b0);
    checks++;
    if ({pw_c_pa_vld_o, pw_c_hit_o, pw_c_pa_o} !== {1'b1, 1'b0, 16'h0000}) begin
      failures++;
      $display("FAIL first_miss: got vld=%0d hit=%0d pa=%h want 1/0/0000",
               pw_c_pa_vld_o, pw_c_hit_o, pw_c_pa_o);
    end
    checks++;
    if ({miss_cnt_o, hit_cnt_o} !== {CW'(1), CW'(0)}) begin
      failures++;
      $display("FAIL first_miss_cnt: got mc=%0d hc=%0d want 1/0", miss_cnt_o, hit_cnt_o);
    end
  endtask

  task automatic test_fill_hit();
    step(1'b0, '0, 1'b1, 16'h1234, 16'hABCD, 1'b0);
    step(1'b1, 32'h1234_0000, 1'b0, '0, '0, 1'b0);
    step(1'b0, '0, 1'b0, '0, '0, 1'b0);
    checks++;
    if ({pw_c_pa_vld_o, pw_c_hit_o, pw_c_pa_o} !== {1'b1, 1'b1, 16'hABCD}) begin
      failures++;
      $display("FAIL fill_hit: got vld=%0d hit=%0d pa=%h want 1/1/abcd",
               pw_c_pa_vld_o, pw_c_hit_o, pw_c_pa_o);
    end
  endtask

  // Nine fills into an empty 8-entry table, then back-to-back lookups.
  task automatic test_back_to_back();
    logic [15:0] want_pa;
    step(1'b0, '0, 1'b0, '0, '0, 1'b1);
    for (int k = 0; k < 9; k++) step(1'b0, '0, 1'b1, 16'(k), 16'(16'h1000 + k), 1'b0);
    for (int k = 0; k < 10; k++) begin
      step(k < 9, {16'(k), 16'(k * 3)}, 1'b0, '0, '0, 1'b0);
      if (k >= 1) begin
        want_pa = (k == 1) ? 16'h0000 : 16'(16'h1000 + k - 1);
        checks++;
        if ({pw_c_pa_vld_o, pw_c_hit_o, pw_c_pa_o} !== {1'b1, (k != 1), want_pa}) begin
          failures++;
          $display("FAIL rr_lookup tag=%0d: got vld=%0d hit=%0d pa=%h want 1/%0d/%h",
                   k - 1, pw_c_pa_vld_o, pw_c_hit_o, pw_c_pa_o, (k != 1), want_pa);
        end
      end
    end
    // Victim pointer must now be 1: tag 9 evicts tag 1.
    step(1'b0, '0, 1'b1, 16'h0009, 16'h1009, 1'b0);
    step(1'b1, 32'h0001_0000, 1'b0, '0, '0, 1'b0);
    step(1'b1, 32'h0009_0000, 1'b0, '0, '0, 1'b0);
    step(1'b0, '0, 1'b0, '0, '0, 1'b0);
    checks++;
    if ({pw_c_pa_vld_o, pw_c_hit_o, pw_c_pa_o} !== {1'b1, 1'b1, 16'h1009}) begin
      failures++;
      $display("FAIL rr_ptr_one: got vld=%0d hit=%0d pa=%h want 1/1/1009",
               pw_c_pa_vld_o, pw_c_hit_o, pw_c_pa_o);
    end
    checks++;
    if ({hit_cnt_o, miss_cnt_o} !== {sat(m_hits), sat(m_misses)}) begin
      failures++;
      $display("FAIL b2b_cnt: got hc=%0d mc=%0d want %0d/%0d",
               hit_cnt_o, miss_cnt_o, sat(m_hits), sat(m_misses));
    end
  endtask

  task automatic test_same_cycle_fill();
    step(1'b1, 32'h00FF_0000, 1'b1, 16'h00FF, 16'h5555, 1'b0);
    step(1'b0, '0, 1'b0, '0, '0, 1'b0);
    checks++;
    if ({pw_c_pa_vld_o, pw_c_hit_o, pw_c_pa_o} !== {1'b1, 1'b1, 16'h5555}) begin
      failures++;
      $display("FAIL same_cycle_fill: got vld=%0d hit=%0d pa=%h want 1/1/5555",
               pw_c_pa_vld_o, pw_c_hit_o, pw_c_pa_o);
    end
    step(1'b0, '0, 1'b1, 16'h00FF, 16'h6666, 1'b0);
    step(1'b1, 32'h00FF_1234, 1'b0, '0, '0, 1'b0);
    step(1'b0, '0, 1'b1, 16'h0077, 16'h7777, 1'b0);
    checks++;
    if ({pw_c_pa_vld_o, pw_c_hit_o, pw_c_pa_o} !== {1'b1, 1'b1, 16'h6666}) begin
      failures++;
      $display("FAIL refill_update: got vld=%0d hit=%0d pa=%h want 1/1/6666",
               pw_c_pa_vld_o, pw_c_hit_o, pw_c_pa_o);
    end
    // The refill did not advance the victim: 0x77 evicted tag 3, tag 4 survives.
    step(1'b1, 32'h0003_0000, 1'b0, '0, '0, 1'b0);
    step(1'b1, 32'h0004_0000, 1'b0, '0, '0, 1'b0);
    checks++;
    if ({pw_c_pa_vld_o, pw_c_hit_o, pw_c_pa_o} !== {1'b1, 1'b0, 16'h0000}) begin
      failures++;
      $display("FAIL evict_tag3: got vld=%0d hit=%0d pa=%h want 1/0/0000",
               pw_c_pa_vld_o, pw_c_hit_o, pw_c_pa_o);
    end
    step(1'b0, '0, 1'b0, '0, '0, 1'b0);
    checks++;
    if ({pw_c_pa_vld_o, pw_c_hit_o, pw_c_pa_o} !== {1'b1, 1'b1, 16'h1004}) begin
      failures++;
      $display("FAIL keep_tag4: got vld=%0d hit=%0d pa=%h want 1/1/1004",
               pw_c_pa_vld_o, pw_c_hit_o, pw_c_pa_o);
    end
  endtask

  task automatic test_flush();
    step(1'b1, 32'h0004_0000, 1'b0, '0, '0, 1'b0);
    step(1'b1, 32'h0004_0000, 1'b1, 16'h0042, 16'h4242, 1'b1);
    checks++;
    if ({pw_c_pa_vld_o, pw_c_hit_o, pw_c_pa_o} !== {1'b1, 1'b1, 16'h1004}) begin
      failures++;
      $display("FAIL flush_s2_kept: got vld=%0d hit=%0d pa=%h want 1/1/1004",
               pw_c_pa_vld_o, pw_c_hit_o, pw_c_pa_o);
    end
    step(1'b1, {16'h0042, 16'($urandom)}, 1'b0, '0, '0, 1'b0);
    checks++;
    if ({pw_c_pa_vld_o, pw_c_hit_o, pw_c_pa_o} !== {1'b1, 1'b0, 16'h0000}) begin
      failures++;
      $display("FAIL flush_same_cycle_req: got vld=%0d hit=%0d pa=%h want 1/0/0000",
               pw_c_pa_vld_o, pw_c_hit_o, pw_c_pa_o);
    end
    step(1'b0, '0, 1'b0, '0, '0, 1'b0);
    checks++;
    if ({pw_c_pa_vld_o, pw_c_hit_o, pw_c_pa_o} !== {1'b1, 1'b0, 16'h0000}) begin
      failures++;
      $display("FAIL flush_drops_fill: got vld=%0d hit=%0d pa=%h want 1/0/0000",
               pw_c_pa_vld_o, pw_c_hit_o, pw_c_pa_o);
    end
    checks++;
    if ({hit_cnt_o, miss_cnt_o} !== {sat(m_hits), sat(m_misses)}) begin
      failures++;
      $display("FAIL flush_cnt_kept: got hc=%0d mc=%0d want %0d/%0d",
               hit_cnt_o, miss_cnt_o, sat(m_hits), sat(m_misses));
    end
  endtask

  task automatic test_reset_midstream();
    step(1'b0, '0, 1'b1, 16'h0042, 16'h4242, 1'b0);
    for (int k = 0; k < 20; k++) begin
      if (k == 10) begin
        #2 resetn_i = 1'b0;
        #1;
        checks++;
        if ({pw_c_pa_vld_o, pw_c_hit_o, pw_c_pa_o, hit_cnt_o, miss_cnt_o} !== '0) begin
          failures++;
          $display("FAIL async_reset: got vld=%0d hit=%0d pa=%h hc=%0d mc=%0d want all 0",
                   pw_c_pa_vld_o, pw_c_hit_o, pw_c_pa_o, hit_cnt_o, miss_cnt_o);
        end
        model_reset();
        pw_c_vld_i = 1'b1; pw_c_va_i = 32'h0042_0000;
        @(posedge clk_i);
        #1;
        pw_c_vld_i = 1'b0;
        resetn_i = 1'b1;
        $display("midstream reset pulse done");
      end
      step(1'b1, {16'(16'h0042 + $urandom_range(0, 1)), 16'($urandom)}, 1'b0, '0, '0, 1'b0);
      checks++;
      if ({pw_c_pa_vld_o, pw_c_hit_o, pw_c_pa_o, hit_cnt_o, miss_cnt_o} !==
          {exp_vld, exp_hit, exp_pa, sat(m_hits), sat(m_misses)}) begin
        failures++;
        $display("FAIL midstream k=%0d: got %0d/%0d/%h hc=%0d mc=%0d want %0d/%0d/%h hc=%0d mc=%0d",
                 k, pw_c_pa_vld_o, pw_c_hit_o, pw_c_pa_o, hit_cnt_o, miss_cnt_o,
                 exp_vld, exp_hit, exp_pa, sat(m_hits), sat(m_misses));
      end
    end
  endtask

  // Small tag pool keeps hits, updates, evictions and counter saturation frequent.
  task automatic test_random();
    bit          req, fv, fl;
    logic [15:0] rtag, ftag;
    for (int k = 0; k < 400; k++) begin
      req  = ($urandom_range(0, 9) < 7);
      fv   = ($urandom_range(0, 9) < 3);
      fl   = ($urandom_range(0, 99) < 3);
      rtag = 16'($urandom_range(0, 11));
      ftag = 16'($urandom_range(0, 11));
      step(req, {rtag, 16'($urandom)}, fv, ftag, 16'($urandom), fl);
      checks++;
      if ({pw_c_pa_vld_o, pw_c_hit_o, pw_c_pa_o, hit_cnt_o, miss_cnt_o} !==
          {exp_vld, exp_hit, exp_pa, sat(m_hits), sat(m_misses)}) begin
        failures++;
        $display("FAIL random k=%0d: got %0d/%0d/%h hc=%0d mc=%0d want %0d/%0d/%h hc=%0d mc=%0d",
                 k, pw_c_pa_vld_o, pw_c_hit_o, pw_c_pa_o, hit_cnt_o, miss_cnt_o,
                 exp_vld, exp_hit, exp_pa, sat(m_hits), sat(m_misses));
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_miss_after_reset();
    test_fill_hit();
    test_back_to_back();
    test_same_cycle_fill();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
